// File: rtl/minesweeper_pkg.sv
// Shared definitions for the minesweeper front end.
// Holds command type encodings, the centre-button FSM state type and the
// default grid dimensions used by cursor_controller and axis_counter.
// No ports (package).
package minesweeper_pkg;

  // Command type carried on CMD_TYPE
  localparam logic CMD_REVEAL = 1'b0;
  localparam logic CMD_FLAG   = 1'b1;

  // Centre-button FSM states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    ISSUE    = 2'd2,
    WAIT_REL = 2'd3
  } ctr_state_t;

  // Default grid dimensions
  localparam int DEF_ROWS  = 16;
  localparam int DEF_COLS  = 16;
  localparam int DEF_ROW_W = 4;
  localparam int DEF_COL_W = 4;

endpackage

// File: rtl/axis_counter.sv
// One axis of the grid cursor (used once for rows, once for columns).
// Moves POS by +1 on INC and -1 on DEC when EN is high; INC and DEC together
// cancel. At the edges the position wraps when CURSOR_WRAP_EN is defined and
// saturates otherwise (default build).
// Ports:
//   CLK   - clock, rising edge
//   RESET - asynchronous active-low reset, POS returns to 0
//   INC   - one-cycle increment request
//   DEC   - one-cycle decrement request
//   EN    - movement enable
//   POS   - current position, 0..SIZE-1
module axis_counter #(
  parameter int SIZE = 16,
  parameter int W    = 4
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         INC,
  input  logic         DEC,
  input  logic         EN,
  output logic [W-1:0] POS
);

  localparam logic [W-1:0] LAST = W'(SIZE - 1);

  logic [W-1:0] r_pos;
  logic [W-1:0] w_next;

  always_comb begin
    w_next = r_pos;
    // INC and DEC together form no move
    if (EN && (INC != DEC)) begin
      if (INC) begin
        if (r_pos == LAST) begin
`ifdef CURSOR_WRAP_EN
          w_next = '0;
`else
          w_next = r_pos;
`endif
        end else begin
          w_next = r_pos + W'(1);
        end
      end else begin
        if (r_pos == '0) begin
`ifdef CURSOR_WRAP_EN
          w_next = LAST;
`else
          w_next = r_pos;
`endif
        end else begin
          w_next = r_pos - W'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_pos <= '0;
    end else begin
      r_pos <= w_next;
    end
  end

  assign POS = r_pos;

endmodule

// File: rtl/cursor_controller.sv
// Grid cursor and centre-button command generator for the minesweeper front
// end. Direction MCEN pulses move the cursor; a centre press issues REVEAL on
// release or FLAG after LONG_CYCLES of continuous hold, with the coordinates
// captured at press time.
// Optional feature: define CURSOR_WRAP_EN to make the cursor wrap at the grid
// edges (default: saturate); implemented inside axis_counter.
// Ports:
//   CLK, RESET (async active-low)
//   ENABLE          - game active; gates movement and new presses
//   UP/DOWN/LEFT/RIGHT_MCEN - one-cycle move pulses
//   CTR_DPB, CTR_SCEN       - centre-button level and press pulse
//   CUR_ROW, CUR_COL        - cursor position
//   CMD_VALID/TYPE/ROW/COL, CMD_READY - command channel
// Command handshake: CMD_VALID rises with CMD_TYPE/ROW/COL already valid and
// all of them hold steady until a rising edge sees CMD_VALID and CMD_READY
// both high; that edge is the transfer, and CMD_VALID drops after it.
// CMD_VALID never depends on CMD_READY.
module cursor_controller
  import minesweeper_pkg::*;
#(
  parameter int ROWS        = DEF_ROWS,
  parameter int COLS        = DEF_COLS,
  parameter int ROW_W       = DEF_ROW_W,
  parameter int COL_W       = DEF_COL_W,
  parameter int LONG_CYCLES = 1024,
  parameter int CNT_W       = 11
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic             UP_MCEN,
  input  logic             DOWN_MCEN,
  input  logic             LEFT_MCEN,
  input  logic             RIGHT_MCEN,
  input  logic             CTR_DPB,
  input  logic             CTR_SCEN,
  output logic [ROW_W-1:0] CUR_ROW,
  output logic [COL_W-1:0] CUR_COL,
  output logic             CMD_VALID,
  output logic             CMD_TYPE,
  output logic [ROW_W-1:0] CMD_ROW,
  output logic [COL_W-1:0] CMD_COL,
  input  logic             CMD_READY
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_CYCLES - 1);

  logic [ROW_W-1:0] w_row;
  logic [COL_W-1:0] w_col;

  ctr_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_cmd_valid;
  logic             r_cmd_type;
  logic [ROW_W-1:0] r_cmd_row;
  logic [COL_W-1:0] r_cmd_col;

  // UP decrements the row index, DOWN increments it
  axis_counter #(.SIZE(ROWS), .W(ROW_W)) u_row (
    .CLK   (CLK),
    .RESET (RESET),
    .INC   (DOWN_MCEN),
    .DEC   (UP_MCEN),
    .EN    (ENABLE),
    .POS   (w_row)
  );

  axis_counter #(.SIZE(COLS), .W(COL_W)) u_col (
    .CLK   (CLK),
    .RESET (RESET),
    .INC   (RIGHT_MCEN),
    .DEC   (LEFT_MCEN),
    .EN    (ENABLE),
    .POS   (w_col)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_type  <= CMD_REVEAL;
      r_cmd_row   <= '0;
      r_cmd_col   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (CTR_SCEN && ENABLE) begin
            r_cmd_row <= w_row;
            r_cmd_col <= w_col;
            r_cnt     <= '0;
            r_state   <= HOLD;
          end
        end
        HOLD: begin
          // Priority: abort, release (REVEAL), hold expiry (FLAG), count
          if (!ENABLE) begin
            r_state <= WAIT_REL;
          end else if (!CTR_DPB) begin
            r_cmd_type  <= CMD_REVEAL;
            r_cmd_valid <= 1'b1;
            r_state     <= ISSUE;
          end else if (r_cnt == HOLD_LAST) begin
            r_cmd_type  <= CMD_FLAG;
            r_cmd_valid <= 1'b1;
            r_state     <= ISSUE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ISSUE: begin
          if (CMD_READY) begin
            r_cmd_valid <= 1'b0;
            r_state     <= WAIT_REL;
          end
        end
        WAIT_REL: begin
          // A REVEAL arrives here already released and leaves at once
          if (!CTR_DPB) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign CUR_ROW   = w_row;
  assign CUR_COL   = w_col;
  assign CMD_VALID = r_cmd_valid;
  assign CMD_TYPE  = r_cmd_type;
  assign CMD_ROW   = r_cmd_row;
  assign CMD_COL   = r_cmd_col;

endmodule

// File: tb/tb_cursor_controller.sv
// Directed bench for cursor_controller with LONG_CYCLES=16 on a 16x16 grid.
// Expected edge behaviour follows CURSOR_WRAP_EN when the bench is built
// with the same define as the design.
module tb_cursor_controller;

  localparam int ROWS  = 16;
  localparam int COLS  = 16;
  localparam int ROW_W = 4;
  localparam int COL_W = 4;
  localparam int LONG  = 16;

`ifdef CURSOR_WRAP_EN
  localparam logic [ROW_W-1:0] EXP_ROW_UP0  = 4'd15;
  localparam logic [COL_W-1:0] EXP_COL_LFT0 = 4'd15;
  localparam logic [ROW_W-1:0] EXP_ROW_DNMX = 4'd0;
`else
  localparam logic [ROW_W-1:0] EXP_ROW_UP0  = 4'd0;
  localparam logic [COL_W-1:0] EXP_COL_LFT0 = 4'd0;
  localparam logic [ROW_W-1:0] EXP_ROW_DNMX = 4'd15;
`endif

  logic             clk;
  logic             rst_n;
  logic             enable;
  logic             up, down, left, right;
  logic             ctr_dpb, ctr_scen;
  logic [ROW_W-1:0] cur_row;
  logic [COL_W-1:0] cur_col;
  logic             cmd_valid;
  logic             cmd_type;
  logic [ROW_W-1:0] cmd_row;
  logic [COL_W-1:0] cmd_col;
  logic             cmd_ready;

  int errors = 0;
  int checks = 0;

  cursor_controller #(
    .ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W), .COL_W(COL_W),
    .LONG_CYCLES(LONG), .CNT_W(5)
  ) dut (
    .CLK        (clk),
    .RESET      (rst_n),
    .ENABLE     (enable),
    .UP_MCEN    (up),
    .DOWN_MCEN  (down),
    .LEFT_MCEN  (left),
    .RIGHT_MCEN (right),
    .CTR_DPB    (ctr_dpb),
    .CTR_SCEN   (ctr_scen),
    .CUR_ROW    (cur_row),
    .CUR_COL    (cur_col),
    .CMD_VALID  (cmd_valid),
    .CMD_TYPE   (cmd_type),
    .CMD_ROW    (cmd_row),
    .CMD_COL    (cmd_col),
    .CMD_READY  (cmd_ready)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic pulse(input logic u, input logic d, input logic l, input logic r);
    up = u; down = d; left = l; right = r;
    tick();
    up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
  endtask

  task automatic move_to(input int r, input int c);
    for (int i = 0; i < r; i++) pulse(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < c; i++) pulse(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (cur_row !== 4'd0) begin errors++; $display("FAIL reset_cur_row got=%0d exp=0", cur_row); end
    checks++; if (cur_col !== 4'd0) begin errors++; $display("FAIL reset_cur_col got=%0d exp=0", cur_col); end
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_cmd_valid got=%b exp=0", cmd_valid); end
    checks++; if (cmd_type !== 1'b0) begin errors++; $display("FAIL reset_cmd_type got=%b exp=0", cmd_type); end
    checks++; if (cmd_row !== 4'd0) begin errors++; $display("FAIL reset_cmd_row got=%0d exp=0", cmd_row); end
    checks++; if (cmd_col !== 4'd0) begin errors++; $display("FAIL reset_cmd_col got=%0d exp=0", cmd_col); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_move();
    do_reset();
    move_to(2, 3);
    checks++; if (cur_col !== 4'd3) begin errors++; $display("FAIL move_col got=%0d exp=3", cur_col); end
    checks++; if (cur_row !== 4'd2) begin errors++; $display("FAIL move_row got=%0d exp=2", cur_row); end
    // reset dropped between clock edges must clear the cursor at once
    right = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (cur_row !== 4'd0 || cur_col !== 4'd0) begin
      errors++; $display("FAIL async_reset got=(%0d,%0d) exp=(0,0)", cur_row, cur_col);
    end
    right = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (cur_col !== 4'd0) begin errors++; $display("FAIL after_reset_col got=%0d exp=0", cur_col); end
  endtask

  task automatic test_edges();
    do_reset();
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (cur_row !== EXP_ROW_UP0) begin errors++; $display("FAIL up_at_row0 got=%0d exp=%0d", cur_row, EXP_ROW_UP0); end
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (cur_col !== EXP_COL_LFT0) begin errors++; $display("FAIL left_at_col0 got=%0d exp=%0d", cur_col, EXP_COL_LFT0); end
    do_reset();
    move_to(3, 0);
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    checks++; if (cur_row !== 4'd3) begin errors++; $display("FAIL up_down_cancel got=%0d exp=3", cur_row); end
    pulse(1'b0, 1'b1, 1'b0, 1'b1);
    checks++; if (cur_row !== 4'd4 || cur_col !== 4'd1) begin
      errors++; $display("FAIL diag_move got=(%0d,%0d) exp=(4,1)", cur_row, cur_col);
    end
    pulse(1'b1, 1'b1, 1'b1, 1'b1);
    checks++; if (cur_row !== 4'd4 || cur_col !== 4'd1) begin
      errors++; $display("FAIL all_cancel got=(%0d,%0d) exp=(4,1)", cur_row, cur_col);
    end
    move_to(11, 0);
    checks++; if (cur_row !== 4'd15) begin errors++; $display("FAIL row_to_max got=%0d exp=15", cur_row); end
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (cur_row !== EXP_ROW_DNMX) begin errors++; $display("FAIL down_at_max got=%0d exp=%0d", cur_row, EXP_ROW_DNMX); end
  endtask

  task automatic test_reveal();
    int n_xfer;
    logic got_type;
    logic [ROW_W-1:0] got_row;
    logic [COL_W-1:0] got_col;
    do_reset();
    move_to(5, 7);
    cmd_ready = 1'b1;
    ctr_scen = 1'b1; ctr_dpb = 1'b1;
    tick();
    ctr_scen = 1'b0;
    tick(); tick(); tick();
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reveal_early_valid got=%b exp=0", cmd_valid); end
    ctr_dpb = 1'b0;
    n_xfer = 0; got_type = 1'bx; got_row = 'x; got_col = 'x;
    for (int k = 0; k < 12; k++) begin
      if (cmd_valid && cmd_ready) begin
        n_xfer++; got_type = cmd_type; got_row = cmd_row; got_col = cmd_col;
      end
      tick();
    end
    checks++; if (n_xfer !== 1) begin errors++; $display("FAIL reveal_count got=%0d exp=1", n_xfer); end
    checks++; if (got_type !== 1'b0) begin errors++; $display("FAIL reveal_type got=%b exp=0", got_type); end
    checks++; if (got_row !== 4'd5 || got_col !== 4'd7) begin
      errors++; $display("FAIL reveal_coord got=(%0d,%0d) exp=(5,7)", got_row, got_col);
    end
  endtask

  task automatic test_flag();
    int n_xfer;
    int first_k;
    logic got_type;
    logic [ROW_W-1:0] got_row;
    logic [COL_W-1:0] got_col;
    bit seen;
    do_reset();
    move_to(2, 2);
    cmd_ready = 1'b1;
    ctr_scen = 1'b1; ctr_dpb = 1'b1;
    n_xfer = 0; first_k = -1; got_type = 1'bx; got_row = 'x; got_col = 'x;
    for (int k = 0; k < 46; k++) begin
      if (k == 1)  ctr_scen = 1'b0;
      if (k == 25) ctr_scen = 1'b1;  // press pulse while waiting for release
      if (k == 26) ctr_scen = 1'b0;
      if (k == 40) ctr_dpb = 1'b0;
      if (cmd_valid && cmd_ready) begin
        n_xfer++;
        if (first_k < 0) begin
          first_k = k; got_type = cmd_type; got_row = cmd_row; got_col = cmd_col;
        end
      end
      tick();
    end
    checks++; if (n_xfer !== 1) begin errors++; $display("FAIL flag_count got=%0d exp=1", n_xfer); end
    checks++; if (first_k !== LONG + 1) begin errors++; $display("FAIL flag_latency got=%0d exp=%0d", first_k, LONG + 1); end
    checks++; if (got_type !== 1'b1) begin errors++; $display("FAIL flag_type got=%b exp=1", got_type); end
    checks++; if (got_row !== 4'd2 || got_col !== 4'd2) begin
      errors++; $display("FAIL flag_coord got=(%0d,%0d) exp=(2,2)", got_row, got_col);
    end
    // a fresh short press after the release must be accepted
    ctr_scen = 1'b1; ctr_dpb = 1'b1;
    tick();
    ctr_scen = 1'b0; ctr_dpb = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6 && !seen; k++) begin
      if (cmd_valid) seen = 1'b1; else tick();
    end
    checks++; if (!seen) begin errors++; $display("FAIL flag_next_press got=no_valid exp=valid"); end
    checks++; if (cmd_type !== 1'b0) begin errors++; $display("FAIL flag_next_type got=%b exp=0", cmd_type); end
    tick();
  endtask

  task automatic test_back_to_back_pressure();
    bit seen;
    int bad;
    do_reset();
    move_to(3, 4);
    cmd_ready = 1'b0;
    ctr_scen = 1'b1; ctr_dpb = 1'b1;
    tick();
    ctr_scen = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (cmd_valid) seen = 1'b1; else tick();
    end
    checks++; if (!seen) begin errors++; $display("FAIL bp_wait got=timeout exp=valid"); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      right = (i % 2 == 0);
      if (cmd_valid !== 1'b1 || cmd_type !== 1'b1 || cmd_row !== 4'd3 || cmd_col !== 4'd4) bad++;
      tick();
    end
    right = 1'b0;
    checks++; if (bad !== 0) begin errors++; $display("FAIL bp_stable got=%0d_bad_cycles exp=0", bad); end
    checks++; if (cur_col !== 4'd9) begin errors++; $display("FAIL bp_cursor_col got=%0d exp=9", cur_col); end
    cmd_ready = 1'b1;
    tick();
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL bp_transfer got=%b exp=0", cmd_valid); end
    ctr_dpb = 1'b0;
    tick(); tick();
  endtask

  task automatic test_enable();
    int n_valid;
    bit seen;
    do_reset();
    cmd_ready = 1'b1;
    // drop ENABLE while holding
    ctr_scen = 1'b1; ctr_dpb = 1'b1;
    tick();
    ctr_scen = 1'b0; enable = 1'b0;
    tick();
    enable = 1'b1;
    n_valid = 0;
    for (int k = 0; k < 20; k++) begin
      if (cmd_valid) n_valid++;
      tick();
    end
    checks++; if (n_valid !== 0) begin errors++; $display("FAIL en_abort got=%0d exp=0", n_valid); end
    ctr_dpb = 1'b0;
    tick(); tick();
    // back in IDLE: a short press works
    ctr_scen = 1'b1; ctr_dpb = 1'b1;
    tick();
    ctr_scen = 1'b0; ctr_dpb = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6 && !seen; k++) begin
      if (cmd_valid) seen = 1'b1; else tick();
    end
    checks++; if (!seen) begin errors++; $display("FAIL en_idle_again got=no_valid exp=valid"); end
    tick(); tick();
    // press while disabled is ignored
    enable = 1'b0;
    ctr_scen = 1'b1; ctr_dpb = 1'b1;
    tick();
    ctr_scen = 1'b0; enable = 1'b1;
    n_valid = 0;
    for (int k = 0; k < 24; k++) begin
      if (k == 20) ctr_dpb = 1'b0;
      if (cmd_valid) n_valid++;
      tick();
    end
    checks++; if (n_valid !== 0) begin errors++; $display("FAIL en_scen_ignored got=%0d exp=0", n_valid); end
    // movement ignored while disabled
    enable = 1'b0;
    pulse(1'b0, 1'b1, 1'b0, 1'b1);
    enable = 1'b1;
    checks++; if (cur_row !== 4'd0 || cur_col !== 4'd0) begin
      errors++; $display("FAIL en_move_ignored got=(%0d,%0d) exp=(0,0)", cur_row, cur_col);
    end
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    rst_n = 1'b1; enable = 1'b1;
    up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
    ctr_dpb = 1'b0; ctr_scen = 1'b0; cmd_ready = 1'b0;
    test_reset();
    test_move();
    test_edges();
    test_reveal();
    test_flag();
    test_back_to_back_pressure();
    test_enable();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
